// File: rtl/rgb_cmd_sequencer_if.sv
// rgb_cmd_sequencer_if: received-byte stream from the UART receiver into the sequencer.
interface rgb_cmd_sequencer_if;
  logic [7:0] rx_data;
  logic       rx_data_ready;
  modport master (output rx_data, rx_data_ready);
  modport slave  (input  rx_data, rx_data_ready);
endinterface

// File: rtl/rgb_cmd_sequencer.sv
// rgb_cmd_sequencer: parses colour/duration byte pairs into a FIFO and plays them on two active-low RGB LEDs.
// Define RGB_PWM_EN to dim lit LEDs to a 25% duty cycle with a free-running 8-bit counter.
module rgb_cmd_sequencer #(
  parameter int CLK_FREQ = 12000000,
  parameter int TICK_HZ  = 10,
  parameter int DEPTH    = 8
) (
  input  logic                       int_clk,
  input  logic                       rst,
  rgb_cmd_sequencer_if.slave         rx,
  output logic                       rgb1_red,
  output logic                       rgb1_green,
  output logic                       rgb1_blue,
  output logic                       rgb2_red,
  output logic                       rgb2_green,
  output logic                       rgb2_blue,
  output logic                       busy,
  output logic                       q_full,
  output logic                       err
);
  localparam int CYC = CLK_FREQ / TICK_HZ;
  localparam int TW  = $clog2(9 * CYC + 1);
  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = AW + 1;
  typedef enum logic       {P_CMD, P_DUR} p_t;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HOLD} s_t;
  p_t            p, p_n;
  s_t            s, s_n;
  logic [2:0]    col_l, col_n, led, led_n, col_of;
  logic [6:0]    mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [CW-1:0] count;
  logic [TW-1:0] timer, timer_n;
  logic [7:0]    b;
  logic [3:0]    dig;
  logic          is_col, is_dig, push, flush, bad, wr, pop, expire, gate;
  assign b      = rx.rx_data;
  assign is_col = b inside {"r", "g", "b", "w", "k"};
  assign is_dig = b >= "0" && b <= "9";
  assign dig    = 4'(b - "0");
  assign col_of = b == "r" ? 3'b100 : b == "g" ? 3'b010 : b == "b" ? 3'b001 :
                  b == "w" ? 3'b111 : 3'b000;
  always_comb begin
    p_n   = p;
    col_n = col_l;
    push  = 1'b0;
    flush = 1'b0;
    bad   = 1'b0;
    if (rx.rx_data_ready) begin
      if (b == "x") begin
        flush = 1'b1;
        p_n   = P_CMD;
      end else if (p == P_CMD) begin
        col_n = is_col ? col_of : col_l;
        p_n   = is_col ? P_DUR : P_CMD;
        bad   = !is_col;
      end else begin
        p_n  = P_CMD;
        push = is_dig;
        bad  = !is_dig;
      end
    end
  end
  // a full queue drops the new entry even if an entry leaves this same cycle
  assign q_full = count == CW'(DEPTH);
  assign wr     = push && !q_full;
  assign expire = s == S_RUN && timer == TW'(1);
  assign pop    = !flush && |count && (s != S_RUN || expire);
  assign busy   = s != S_IDLE;
  always_comb begin
    s_n     = flush ? S_IDLE : pop ? (|mem[rp][3:0] ? S_RUN : S_HOLD) : expire ? S_IDLE : s;
    timer_n = flush ? '0 : pop ? TW'(int'(mem[rp][3:0]) * CYC) :
              (s == S_RUN && |timer) ? timer - TW'(1) : timer;
    led_n   = flush ? 3'b111 : pop ? ~mem[rp][6:4] : expire ? 3'b111 : led;
  end
  always_ff @(posedge int_clk or posedge rst)
    if (rst) begin
      p     <= P_CMD;
      s     <= S_IDLE;
      col_l <= '0;
      led   <= 3'b111;
      timer <= '0;
      wp    <= '0;
      rp    <= '0;
      count <= '0;
      err   <= 1'b0;
    end else begin
      p     <= p_n;
      s     <= s_n;
      col_l <= col_n;
      led   <= led_n;
      timer <= timer_n;
      err   <= bad || (push && q_full);
      wp    <= flush ? '0 : wp + AW'(wr);
      rp    <= flush ? '0 : rp + AW'(pop);
      count <= flush ? '0 : count + CW'(wr) - CW'(pop);
    end
  always_ff @(posedge int_clk)
    if (wr) mem[wp] <= {col_l, dig};
`ifdef RGB_PWM_EN
  logic [7:0] pwm;
  always_ff @(posedge int_clk or posedge rst)
    if (rst) pwm <= '0;
    else pwm <= pwm + 8'd1;
  assign gate = |pwm[7:6];
`else
  assign gate = 1'b0;
`endif
  assign {rgb1_red, rgb1_green, rgb1_blue} = led | {3{gate}};
  assign {rgb2_red, rgb2_green, rgb2_blue} = led | {3{gate}};
endmodule

// File: tb/tb_rgb_cmd_sequencer.sv
// tb_rgb_cmd_sequencer: directed byte stream with a scoreboard of expected colour steps.
module tb_rgb_cmd_sequencer;
  localparam int DEPTH = 8;
  logic int_clk = 1'b0, rst = 1'b0;
  logic r1, g1, b1, r2, g2, b2, busy, q_full, err;
  always #5 int_clk = ~int_clk;
  rgb_cmd_sequencer_if rx();
  rgb_cmd_sequencer #(.CLK_FREQ(1000), .TICK_HZ(100), .DEPTH(DEPTH)) dut (
    .int_clk(int_clk), .rst(rst), .rx(rx),
    .rgb1_red(r1), .rgb1_green(g1), .rgb1_blue(b1),
    .rgb2_red(r2), .rgb2_green(g2), .rgb2_blue(b2),
    .busy(busy), .q_full(q_full), .err(err));
  typedef struct { logic [2:0] led; int len; } step_t;
  step_t sb[$];
  step_t e_m;
  int checks = 0, errors = 0;
  logic [3:0] cur = 4'b0111;
  int run = 0;
  wire [2:0] led1 = {r1, g1, b1};
  wire [2:0] led2 = {r2, g2, b2};
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask
  task automatic outs(string tag, logic [2:0] l, logic bz);
    chk({tag, "_led1"}, 32'(led1), 32'(l));
    chk({tag, "_led2"}, 32'(led2), 32'(l));
    chk({tag, "_busy"}, 32'(busy), 32'(bz));
  endtask
  task automatic send(byte v);
    @(negedge int_clk);
    rx.rx_data = v;
    rx.rx_data_ready = 1'b1;
    @(negedge int_clk);
    rx.rx_data_ready = 1'b0;
  endtask
  task automatic expect_step(logic [2:0] l, int len);
    sb.push_back('{l, len});
  endtask
  task automatic wait_idle(int lim);
    int n = 0;
    repeat (2) @(negedge int_clk);
    while (busy && n < lim) begin
      @(negedge int_clk);
      n++;
    end
    chk("idle_timeout", 32'(busy), 0);
    @(negedge int_clk);
    #1;
    chk("sb_drained", sb.size(), 0);
  endtask
  // each busy segment of constant colour is one played step
  always @(negedge int_clk) begin
    if ({busy, led1} !== cur) begin
      if (cur[3]) begin
        chk("step_present", 32'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
          e_m = sb.pop_front();
          chk("step_led", 32'(cur[2:0]), 32'(e_m.led));
          if (e_m.len != 0) chk("step_len", run, e_m.len);
        end
      end
      cur = {busy, led1};
      run = 1;
    end else run++;
  end
  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1);
  end
  initial begin
    rx.rx_data = 8'h00;
    rx.rx_data_ready = 1'b0;
    #1 rst = 1'b1;
    #1;
    outs("reset", 3'b111, 1'b0);
    chk("reset_qfull", 32'(q_full), 0);
    chk("reset_err", 32'(err), 0);
    @(negedge int_clk);
    rst = 1'b0;
    expect_step(3'b011, 30);
    send("r");
    send("3");
    outs("lat_n1", 3'b111, 1'b0);
    @(negedge int_clk);
    outs("lat_n2", 3'b011, 1'b1);
    wait_idle(100);
    expect_step(3'b101, 20);
    expect_step(3'b110, 10);
    send("g"); send("2"); send("b"); send("1");
    wait_idle(200);
    expect_step(3'b000, 0);
    expect_step(3'b111, 10);
    send("w"); send("0");
    repeat (500) @(negedge int_clk);
    outs("hold", 3'b000, 1'b1);
    send("k"); send("1");
    wait_idle(100);
    expect_step(3'b011, 90);
    send("r"); send("9");
    for (int i = 0; i < DEPTH + 1; i++) begin
      if (i < DEPTH) expect_step(i % 2 ? 3'b110 : 3'b101, 10);
      send(i % 2 ? "b" : "g");
      send("1");
      if (i == DEPTH - 2) chk("qfull_pre", 32'(q_full), 0);
      if (i == DEPTH - 1) begin
        chk("qfull_set", 32'(q_full), 1);
        chk("qfull_no_err", 32'(err), 0);
      end
      if (i == DEPTH) begin
        chk("drop_err", 32'(err), 1);
        chk("drop_qfull", 32'(q_full), 1);
      end
    end
    wait_idle(400);
    send("q");
    chk("bad_cmd_err", 32'(err), 1);
    send("r");
    chk("good_cmd_err", 32'(err), 0);
    send("z");
    chk("bad_dur_err", 32'(err), 1);
    repeat (20) @(negedge int_clk);
    outs("rejected", 3'b111, 1'b0);
    chk("rejected_qfull", 32'(q_full), 0);
    expect_step(3'b011, 0);
    send("r"); send("9");
    send("g"); send("1"); send("b"); send("1"); send("g"); send("1");
    outs("pre_flush", 3'b011, 1'b1);
    send("x");
    outs("flush", 3'b111, 1'b0);
    chk("flush_qfull", 32'(q_full), 0);
    repeat (30) @(negedge int_clk);
    outs("post_flush", 3'b111, 1'b0);
    #1;
    chk("flush_sb", sb.size(), 0);
    expect_step(3'b101, 0);
    send("g"); send("9");
    repeat (5) @(negedge int_clk);
    outs("pre_rst", 3'b101, 1'b1);
    #2 rst = 1'b1;
    #1;
    outs("async_rst", 3'b111, 1'b0);
    chk("async_rst_qfull", 32'(q_full), 0);
    chk("async_rst_err", 32'(err), 0);
    @(negedge int_clk);
    rst = 1'b0;
    expect_step(3'b110, 10);
    send("b"); send("1");
    wait_idle(100);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/rgb_cmd_sequencer.md
Name: rgb_cmd_sequencer

Overview:
Command scheduler that sits between the UART byte receiver and the two on-board RGB LEDs. It parses two-byte colour/duration commands from the received byte stream and queues them in a small FIFO. It then plays them out in order, timing each colour step and driving the six active-low LED outputs. It replaces direct byte-to-LED decoding so the host can download whole colour sequences.

Parameters:
CLK_FREQ, 12000000, int_clk frequency in Hz
TICK_HZ, 10, duration tick rate in Hz (one tick = CLK_FREQ/TICK_HZ cycles)
DEPTH, 8, queue entries (power of two, >=2)

Ports:
int_clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
rx_data  in  8  received byte, valid when rx_data_ready=1
rx_data_ready  in  1  single-cycle strobe, one per byte
rgb1_red, rgb1_green, rgb1_blue  out  1 each  LED1 drive, active-low
rgb2_red, rgb2_green, rgb2_blue  out  1 each  LED2 drive, active-low (mirrors LED1)
busy  out  1  scheduler is not in S_IDLE
q_full  out  1  queue count == DEPTH
err  out  1  one-cycle pulse on rejected byte or dropped entry

Behaviour:
- Reset (async): all six LED outputs 1 (off), busy=0, q_full=0, err=0, queue empty, parser in P_CMD, scheduler in S_IDLE, tick counter 0.
- Colour map, as RGB bits: 'r'=100, 'g'=010, 'b'=001, 'w'=111, 'k'=000. LED outputs = ~colour, registered, identical on LED1 and LED2.
- Parser FSM, advances only on rx_data_ready:
  - P_CMD: colour char -> latch colour, go to P_DUR. 'x' -> flush. Any other byte -> err pulse, stay in P_CMD.
  - P_DUR: '0'..'9' -> enqueue {colour, digit}, go to P_CMD. 'x' -> flush, go to P_CMD. Any other byte -> err pulse, drop the latched colour, go to P_CMD.
  - Enqueue while count==DEPTH (count sampled before this cycle; a simultaneous pop does not help) -> entry dropped, err pulse.
- Flush ('x'): next edge empties the queue, scheduler goes to S_IDLE, LEDs go off, timer clears. Takes priority over any pop in the same cycle.
- Scheduler FSM:
  - S_IDLE: LEDs off. Queue non-empty -> pop.
  - Pop: load colour onto the LEDs on the following edge. Digit d>0 -> S_RUN with timer = d*(CLK_FREQ/TICK_HZ). d=0 -> S_HOLD.
  - S_RUN: colour is held exactly d*CLK_FREQ/TICK_HZ cycles. On the expiry cycle, pop the next entry if one is present (no gap cycle); otherwise go to S_IDLE (LEDs off next cycle).
  - S_HOLD: colour is held indefinitely. The first cycle the queue is non-empty, pop as above.
- Latency: duration byte strobed at cycle N -> entry written at the end of N -> idle scheduler pops at N+1 -> LEDs change at the N+2 edge.
- Timer width: ceil(log2(9*CLK_FREQ/TICK_HZ+1)) bits. Queue pointers wrap modulo DEPTH. Count width is log2(DEPTH)+1.
- A strobe arriving during a step is parsed normally; the current step is unaffected unless the byte is 'x'.

Optional Feature:
RGB_PWM_EN — when defined, an 8-bit free-running counter (reset 0) gates the LEDs: a lit colour bit drives low only while counter[7:6]==00, giving a 25% duty cycle, and outputs are high otherwise. Timing, queueing and busy are unchanged. When undefined, lit bits drive low continuously.

Test Plan:
- CLK_FREQ=1000, TICK_HZ=100 (10 cycles/tick); send 'r','3' -> LEDs show ~100 from N+2 for exactly 30 cycles, then all 1, busy falls.
- Send 'g','2' then 'b','1' back-to-back -> green for 20 cycles, blue the very next cycle for 10 cycles, then off; no gap cycle between the steps.
- Send 'w','0', wait 500 cycles, then 'k','1' -> white held throughout the 500 cycles; 'k' is displayed (LEDs all 1) once popped, for 10 cycles.
- Fill DEPTH+1 entries while a 'r','9' step runs -> q_full=1 after DEPTH entries, the extra entry gives an err pulse and is dropped, and exactly DEPTH steps play afterwards.
- Send 'q', then 'r','z' -> two err pulses, nothing enqueued, LEDs stay off.
- Queue 3 entries mid-step, then send 'x' -> next cycle LEDs off, busy=0, queue empty. Separately, assert rst mid-step -> outputs return to reset values immediately, with no clock edge needed.
